// File: rtl/fizzbuzz_pkg.sv
// -----------------------------------------------------------------------------
// fizzbuzz_pkg
//
// Shared definitions for the fizzbuzz output formatter:
//   fmt_state_t  - formatter FSM states (IDLE, CONV, WORD, DIGIT, EOL)
//   ASCII_*      - character codes used to build "Fizz", "Buzz", digits and EOL
//   num_digits() - decimal digit count of a non-negative value (minimum 1),
//                  used to size the BCD vector at elaboration time
//   word_char()  - character ROM for the two four-letter words
// -----------------------------------------------------------------------------
package fizzbuzz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WORD,
        DIGIT,
        EOL
    } fmt_state_t;

    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_I  = 8'h69;
    localparam logic [7:0] ASCII_U  = 8'h75;
    localparam logic [7:0] ASCII_Z  = 8'h7A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Decimal digit count of value; 0..9 all count as one digit.
    function automatic int num_digits(input int value);
        int v;
        int n;
        v = value;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Both words share the "zz" tail, so only the first two letters differ.
    function automatic logic [7:0] word_char(input logic buzz_half, input logic [1:0] pos);
        logic [7:0] c;
        case (pos)
            2'd0:    c = buzz_half ? ASCII_B : ASCII_F;
            2'd1:    c = buzz_half ? ASCII_U : ASCII_I;
            default: c = ASCII_Z;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fizzbuzz_bin2bcd.sv
// -----------------------------------------------------------------------------
// fizzbuzz_bin2bcd
//
// Sequential double-dabble binary-to-BCD converter. One bit is shifted in per
// cycle; the first shift happens on the start edge itself (the BCD register is
// still zero then, so no add-3 correction is needed), which lets the full
// NUM_W-bit conversion finish NUM_W cycles after start.
//
// Parameters:
//   NUM_W   - binary input width
//   DIGITS  - number of BCD digits produced
// Ports:
//   clk    in   1          clock
//   rst    in   1          synchronous active-high reset
//   start  in   1          load bin and begin a conversion
//   bin    in   NUM_W      binary value
//   done   out  1          one-cycle pulse: bcd holds the final result
//   bcd    out  4*DIGITS   BCD result, digit 0 in the low nibble
// -----------------------------------------------------------------------------
module fizzbuzz_bin2bcd
    import fizzbuzz_pkg::*;
#(
    parameter int NUM_W  = 5,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (NUM_W < 2) ? 1 : $clog2(NUM_W + 1);

    logic [BCD_W-1:0] bcd_adj;
    logic [NUM_W-1:0] shift_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;

    // Add-3 correction: any digit of 5 or more would overflow past 9 when
    // doubled by the next shift, so it is pre-biased before shifting.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Shift engine. count_q holds the number of shifts still to do; done is
    // raised together with the last shift so it lines up with the final bcd.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd     <= '0;
            shift_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd     <= BCD_W'(bin[NUM_W-1]);
                shift_q <= bin << 1;
                count_q <= CNT_W'(NUM_W - 1);
                busy_q  <= (NUM_W > 1);
                done    <= (NUM_W == 1);
            end else if (busy_q) begin
                {bcd, shift_q} <= {bcd_adj, shift_q} << 1;
                count_q        <= count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fizzbuzz_formatter.sv
// -----------------------------------------------------------------------------
// fizzbuzz_formatter
//
// Turns one {is_fizz, is_buzz, number} result per handshake into an ASCII
// line: "Fizz", "Buzz", "FizzBuzz" or the decimal number without leading
// zeros, followed by an end-of-line sequence. o_ready is meant to drive the
// generator's i_en, so only one result is ever in flight.
//
// Build option:
//   FIZZBUZZ_FORMATTER_CRLF_EN - when defined the line ends with 0x0D 0x0A,
//                                otherwise with 0x0A alone. o_last marks 0x0A.
//
// Parameters:
//   g_length  - generator count range (numbers are 0 .. g_length-1)
//   NUM_W     - number width, $clog2(g_length)
//   DIGITS    - decimal digits of g_length-1
// Ports:
//   i_clk      in   1       clock
//   i_rst      in   1       synchronous active-high reset
//   i_valid    in   1       upstream result valid
//   i_is_fizz  in   1       number divisible by 3
//   i_is_buzz  in   1       number divisible by 5
//   i_number   in   NUM_W   current number
//   o_ready    out  1       formatter can accept a result
//   o_data     out  8       ASCII byte
//   o_valid    out  1       o_data valid
//   i_ready    in   1       sink accepts byte
//   o_last     out  1       final byte of the line
// -----------------------------------------------------------------------------
module fizzbuzz_formatter
    import fizzbuzz_pkg::*;
#(
    parameter  int g_length = 20,
    localparam int NUM_W    = $clog2(g_length),
    localparam int DIGITS   = num_digits(g_length - 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_is_fizz,
    input  logic             i_is_buzz,
    input  logic [NUM_W-1:0] i_number,
    output logic             o_ready,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = ($clog2(DIGITS) > 3) ? $clog2(DIGITS) : 3;
`ifdef FIZZBUZZ_FORMATTER_CRLF_EN
    localparam int EOL_LEN = 2;
`else
    localparam int EOL_LEN = 1;
`endif

    fmt_state_t       state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             is_fizz_q, is_buzz_q;
    logic             ready_q;

    logic [7:0]       data_q;
    logic             valid_q;
    logic             last_q;

    logic             accept;
    logic             out_free;
    logic             load;
    logic [7:0]       load_data;
    logic             load_last;

    logic             bcd_start;
    logic             bcd_done;
    logic [BCD_W-1:0] bcd;
    logic [IDX_W-1:0] lead_idx;
    logic [3:0]       digit_sel;
    logic [7:0]       word_byte;
    logic [7:0]       eol_byte;
    logic [IDX_W-1:0] word_last;

    assign accept   = (state == IDLE) && ready_q && i_valid;
    assign out_free = !valid_q || i_ready;

    fizzbuzz_bin2bcd #(
        .NUM_W  (NUM_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (i_clk),
        .rst   (i_rst),
        .start (bcd_start),
        .bin   (i_number),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Most-significant nonzero digit is where printing starts; a value of
    // zero leaves the pointer at digit 0 so a single "0" is printed.
    always_comb begin
        lead_idx = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] != 4'd0) begin
                lead_idx = IDX_W'(d);
            end
        end
    end

    // Digit currently pointed at by idx while in DIGIT.
    always_comb begin
        digit_sel = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                digit_sel = bcd[d*4 +: 4];
            end
        end
    end

    // Word ROM: for "FizzBuzz" the upper half of idx (bit 2) selects "Buzz";
    // a lone buzz flag uses "Buzz" from the first character.
    always_comb begin
        word_byte = word_char(is_buzz_q && (!is_fizz_q || idx[2]), idx[1:0]);
        word_last = (is_fizz_q && is_buzz_q) ? IDX_W'(7) : IDX_W'(3);
`ifdef FIZZBUZZ_FORMATTER_CRLF_EN
        eol_byte  = (idx == '0) ? ASCII_CR : ASCII_LF;
`else
        eol_byte  = ASCII_LF;
`endif
    end

    // Next-state logic. A byte is produced only when the output register is
    // empty or being emptied this cycle, so a stalled byte is never replaced.
    // EOL keeps the FSM busy until its final byte has actually left, which
    // keeps o_ready low until the line is fully delivered.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        bcd_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    idx_next = '0;
                    if (i_is_fizz || i_is_buzz) begin
                        state_next = WORD;
                    end else begin
                        state_next = CONV;
                        bcd_start  = 1'b1;
                    end
                end
            end
            CONV: begin
                if (bcd_done) begin
                    state_next = DIGIT;
                    idx_next   = lead_idx;
                end
            end
            WORD: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = word_byte;
                    if (idx == word_last) begin
                        state_next = EOL;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = ASCII_0 + {4'h0, digit_sel};
                    if (idx == '0) begin
                        state_next = EOL;
                    end else begin
                        idx_next = idx - 1'b1;
                    end
                end
            end
            EOL: begin
                if (idx < IDX_W'(EOL_LEN)) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = eol_byte;
                        load_last = (idx == IDX_W'(EOL_LEN - 1));
                        idx_next  = idx + 1'b1;
                    end
                end else if (valid_q && i_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus captured flags. o_ready is registered from the
    // next state so it is low throughout reset and rises one cycle after.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            is_fizz_q <= 1'b0;
            is_buzz_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            ready_q <= (state_next == IDLE);
            if (accept) begin
                is_fizz_q <= i_is_fizz;
                is_buzz_q <= i_is_buzz;
            end
        end
    end

    // Output register: loads a new byte, or empties once its byte transfers.
    // Data is left untouched after a transfer; only valid/last drop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
            last_q  <= load_last;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign o_ready = ready_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;

endmodule

// File: doc/fizzbuzz_formatter.md
# fizzbuzz_formatter

Downstream stage of the fizzbuzz generator: accepts one `{is_fizz, is_buzz, number}` result per handshake and serialises it into an ASCII byte stream, one line per result. Each line is "Fizz", "Buzz", "FizzBuzz" or the decimal number without leading zeros, followed by an end-of-line sequence. Upstream `i_en` is driven from this block's `o_ready`, so the generator advances only when the formatter can take a new value. The byte stream feeds a UART/console sink with valid/ready back-pressure.

## Interface
- `g_length`, default 20: generator count range; must match the upstream generator.
- `NUM_W`, localparam, `$clog2(g_length)`: number width.
- `DIGITS`, localparam: decimal digit count of `g_length-1`, minimum 1.

Ports:
- `i_clk`  in  1: clock. Single clock domain; all state changes on the rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_valid`  in  1: upstream result valid.
- `i_is_fizz`  in  1: number divisible by 3.
- `i_is_buzz`  in  1: number divisible by 5.
- `i_number`  in  NUM_W: current number.
- `o_ready`  out  1: formatter can accept a result. Connect to generator `i_en`.
- `o_data`  out  8: ASCII byte.
- `o_valid`  out  1: `o_data` valid.
- `i_ready`  in  1: sink accepts byte.
- `o_last`  out  1: final byte of the line.

## Operation
- FSM states: IDLE, CONV, WORD, DIGIT, EOL.
- IDLE:
  - `o_ready` = 1.
  - When `i_valid && o_ready`, capture all inputs.
  - If fizz or buzz is set, go to WORD; otherwise go to CONV.
- CONV:
  - Sequential double-dabble binary-to-BCD conversion of the captured number.
  - Takes exactly NUM_W cycles, then goes to DIGIT.
  - Sets the start pointer to the most-significant nonzero digit. A value of 0 emits a single "0".
- WORD emits byte sequences:
  - fizz only: "Fizz" = 0x46 0x69 0x7A 0x7A.
  - buzz only: "Buzz" = 0x42 0x75 0x7A 0x7A.
  - both: "FizzBuzz", 8 bytes.
  - After the last word byte, go to EOL.
- DIGIT: emits BCD digits most-significant first as 0x30+d, then goes to EOL.
- EOL: emits 0x0A with `o_last` = 1, then returns to IDLE.
- Output handshake:
  - A byte transfers when `o_valid && i_ready`.
  - While `o_valid && !i_ready`, `o_data`, `o_valid` and `o_last` hold stable.
  - `o_valid` never deasserts without a transfer.
- `o_ready` = 0 in every state except IDLE. Inputs are ignored outside IDLE.

## Timing
- Reset values while `i_rst` is high:
  - `o_valid` = 0, `o_last` = 0, `o_data` = 0x00, `o_ready` = 0, state = IDLE.
  - `o_ready` rises the first cycle after `i_rst` falls.
- Reset mid-line: the line is abandoned and no further bytes are emitted. The next line starts cleanly.
- Latency from the capture edge to the first `o_valid`:
  - word: 1 cycle.
  - number: 1 + NUM_W cycles.
- With `i_ready` held high, one byte is emitted per cycle.
- After the last byte transfers, `o_ready` = 1 on the next cycle; there is no buffered second result.
- Line lengths at `i_ready` = 1:
  - numbers: digit count + EOL length.
  - "Fizz" / "Buzz": 4 + EOL length.
  - "FizzBuzz": 8 + EOL length.
- Throughput: one result per line duration plus 1 IDLE cycle.

## Configuration
- `FIZZBUZZ_FORMATTER_CRLF_EN` defined: EOL is two bytes, 0x0D then 0x0A. `o_last` is set only on 0x0A.
- Macro undefined: EOL is the single byte 0x0A.
- No other behaviour changes.

## Structure
- Package `fizzbuzz_pkg`:
  - FSM state enum `fmt_state_t`.
  - ASCII constants `ASCII_F`, `ASCII_B`, `ASCII_I`, `ASCII_U`, `ASCII_Z`, `ASCII_0`, `ASCII_CR`, `ASCII_LF`.
  - Function `num_digits(int)` for `DIGITS`.
- Sub-module `fizzbuzz_bin2bcd`: sequential double-dabble engine.
  - Parameters: `NUM_W`, `DIGITS`.
  - Ports: `start`, `bin`, `done` pulse, BCD vector.
- FSM, word ROM, digit pointer and output register live in `fizzbuzz_formatter`.

## Test plan
- Reset, then 1 -> `o_valid` stays 0 throughout; `o_ready` = 0 during reset and 1 on the cycle after release.
- `g_length` = 20, number 3, fizz, `i_ready` = 1 -> bytes 0x46 0x69 0x7A 0x7A 0x0A; first byte on capture+1; `o_last` only on 0x0A.
- Number 15, fizz and buzz -> "FizzBuzz\n", 9 bytes on consecutive cycles.
- Number 7, neither flag -> first byte at capture+1+5 cycles; bytes 0x37 0x0A. Number 11 -> 0x31 0x31 0x0A. Number 0 with no flags -> 0x30 0x0A.
- `i_ready` toggled randomly during "Buzz" -> each byte is held stable while stalled; the sequence is unchanged; `o_ready` stays 0 until 0x0A transfers.
- With `FIZZBUZZ_FORMATTER_CRLF_EN`, number 4 -> 0x34 0x0D 0x0A with `o_last` on 0x0A only. `i_rst` asserted after the first byte -> no further bytes; the next capture emits a complete line.
